arb_requester: RTL and testbench

- Requester-side agent for the ripple-priority arbiter chain: drives one cell's request input r and consumes its grant g.
- Accepts a job from local logic through a valid/ready handshake and raises r until the job's beats are granted.
- Releases r for a mandatory gap cycle so lower-priority cells can win, then accepts the next job.
- Flags starvation when no grant arrives within a bounded number of cycles and counts completed jobs.

---
 rtl/arb_requester_if.sv | 29 ++
 rtl/arb_requester.sv | 114 +++++++++++
 tb/tb_arb_requester.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/arb_requester_if.sv
// rtl/arb_requester_if.sv - job, arbiter and status signal bundle for arb_requester
interface arb_requester_if #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
);
  logic             job_valid;
  logic [LEN_W-1:0] job_len;
  logic             job_ready;
  logic             r;
  logic             g;
  logic             beat;
  logic [LEN_W-1:0] beat_idx;
  logic             done;
  logic             starve;
  logic             starve_clr;
  logic [CNT_W-1:0] jobs_done;

  // requester agent side
  modport master (
    input  job_valid, job_len, g, starve_clr,
    output job_ready, r, beat, beat_idx, done, starve, jobs_done
  );

  // local logic / arbiter cell side
  modport slave (
    output job_valid, job_len, g, starve_clr,
    input  job_ready, r, beat, beat_idx, done, starve, jobs_done
  );
endinterface

// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - requester agent for one cell of the ripple-priority arbiter chain
module arb_requester #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  arb_requester_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;
  localparam logic [7:0] TMO    = 8'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic             r_q, r_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       wait_q, wait_d;
  logic             starve_q, starve_d;
  logic [CNT_W-1:0] jobs_q, jobs_d;

  logic active;
  logic beat;
  logic done;
  logic starve_set;

  // r is 1 only in REQ/XFER, so beat follows g there; REQ/XFER gating keeps IDLE/REL grants inert
  assign active     = (state_q == S_REQ) || (state_q == S_XFER);
  assign beat       = r_q & bus.g & active;
  assign done       = beat & (cnt_q == len_q);
  // set on the no-grant cycle that takes the wait counter to TIMEOUT, and on every one while saturated
  assign starve_set = active & ~bus.g & (wait_q >= (TMO - 8'd1));

  assign bus.job_ready = rst_n & (state_q == S_IDLE);
  assign bus.r         = r_q;
  assign bus.beat      = beat;
  assign bus.beat_idx  = cnt_q;
  assign bus.done      = done;
  assign bus.starve    = starve_q;
  assign bus.jobs_done = jobs_q;

  // next-state for the job FSM, beat/wait counters, starvation flag and job counter
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    jobs_d  = jobs_q;
    case (state_q)
      S_IDLE: begin
        if (bus.job_valid) begin
          state_d = S_REQ;
          r_d     = 1'b1;
          len_d   = bus.job_len;
          cnt_d   = '0;
          wait_d  = '0;
        end
      end
      S_REQ, S_XFER: begin
        if (beat) begin
          wait_d = '0;
          if (done) begin
            state_d = S_REL;
            r_d     = 1'b0;
            cnt_d   = '0;
            jobs_d  = jobs_q + CNT_W'(1);
          end else begin
            state_d = S_XFER;
            cnt_d   = cnt_q + LEN_W'(1);
          end
        end else if (wait_q != TMO) begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (starve_set) begin
      starve_d = 1'b1;
    end else if (bus.starve_clr) begin
      starve_d = 1'b0;
    end else begin
      starve_d = starve_q;
    end
  end

  // state registers; reset drops r at once and discards any in-flight job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      r_q      <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      starve_q <= 1'b0;
      jobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
      jobs_q   <= jobs_d;
    end
  end

endmodule

// File: tb/tb_arb_requester.sv
// tb/tb_arb_requester.sv - randomized self-checking bench for arb_requester
module tb_arb_requester;

  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 8;

  logic clk;
  logic rst_n;

  arb_requester_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  arb_requester #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [CNT_W-1:0] exp_jobs;
  logic             exp_starve;
  bit               pat[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // one whole job: accept cycle, granted/stalled cycles, REL cycle (optionally poked), all checked
  // mode 0: g always 1; 1: random g and starve_clr; 2: g from pat queue then 1; 3: 20 no-grant cycles then 1
  task automatic run_job(input int len, input int mode, input bit poke);
    int beats;
    int cyc;
    int waitc;
    bit gv;
    bit clr;
    bit set;
    bus.job_valid  = 1'b1;
    bus.job_len    = LEN_W'(len);
    bus.g          = (mode == 0) ? 1'b1 : 1'($urandom % 2);
    bus.starve_clr = 1'b0;
    #1;
    total++; if (bus.job_ready !== 1'b1) begin bad++; $display("FAIL accept_ready got=%0b exp=1", bus.job_ready); end
    total++; if (bus.r !== 1'b0) begin bad++; $display("FAIL accept_r got=%0b exp=0", bus.r); end
    total++; if (bus.beat !== 1'b0) begin bad++; $display("FAIL accept_beat got=%0b exp=0", bus.beat); end
    tick();
    bus.job_valid = 1'b0;
    bus.job_len   = LEN_W'($urandom);
    beats = 0;
    cyc   = 0;
    waitc = 0;
    while (beats <= len) begin
      clr = 1'b0;
      case (mode)
        0: gv = 1'b1;
        1: begin gv = (($urandom % 3) != 0) || (cyc >= 30); clr = (($urandom % 6) == 0); end
        2: gv = (pat.size() > 0) ? pat.pop_front() : 1'b1;
        default: begin gv = (cyc >= 20); clr = (cyc == TIMEOUT - 1); end
      endcase
      bus.g          = gv;
      bus.starve_clr = clr;
      #1;
      total++; if (bus.r !== 1'b1) begin bad++; $display("FAIL job_r cyc=%0d got=%0b exp=1", cyc, bus.r); end
      total++; if (bus.job_ready !== 1'b0) begin bad++; $display("FAIL job_ready cyc=%0d got=%0b exp=0", cyc, bus.job_ready); end
      total++; if (bus.beat !== gv) begin bad++; $display("FAIL job_beat cyc=%0d got=%0b exp=%0b", cyc, bus.beat, gv); end
      total++; if (bus.beat_idx !== LEN_W'(beats)) begin bad++; $display("FAIL job_idx cyc=%0d got=%0d exp=%0d", cyc, bus.beat_idx, beats); end
      total++; if (bus.done !== (gv && beats == len)) begin bad++; $display("FAIL job_done cyc=%0d got=%0b exp=%0b", cyc, bus.done, gv && beats == len); end
      total++; if (bus.starve !== exp_starve) begin bad++; $display("FAIL job_starve cyc=%0d got=%0b exp=%0b", cyc, bus.starve, exp_starve); end
      set = !gv && (waitc + 1 >= TIMEOUT);
      if (gv) waitc = 0;
      else if (waitc < TIMEOUT) waitc++;
      if (set) exp_starve = 1'b1;
      else if (clr) exp_starve = 1'b0;
      if (gv) begin
        beats++;
        if (beats > len) exp_jobs = exp_jobs + 1'b1;
      end
      cyc++;
      tick();
    end
    bus.starve_clr = 1'b0;
    bus.job_valid  = poke;
    bus.g          = (mode == 0 || poke) ? 1'b1 : 1'($urandom % 2);
    #1;
    total++; if (bus.r !== 1'b0) begin bad++; $display("FAIL rel_r got=%0b exp=0", bus.r); end
    total++; if (bus.job_ready !== 1'b0) begin bad++; $display("FAIL rel_ready got=%0b exp=0", bus.job_ready); end
    total++; if (bus.beat !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL rel_beat got=%0b%0b exp=00", bus.beat, bus.done); end
    total++; if (bus.jobs_done !== exp_jobs) begin bad++; $display("FAIL rel_jobs got=%0d exp=%0d", bus.jobs_done, exp_jobs); end
    total++; if (bus.starve !== exp_starve) begin bad++; $display("FAIL rel_starve got=%0b exp=%0b", bus.starve, exp_starve); end
    tick();
    bus.job_valid = 1'b0;
    if (poke) begin
      bus.g = 1'b1;
      #1;
      total++; if (bus.job_ready !== 1'b1) begin bad++; $display("FAIL poke_ready got=%0b exp=1", bus.job_ready); end
      total++; if (bus.r !== 1'b0 || bus.beat !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL poke_idle r/beat/done got=%0b%0b%0b exp=000", bus.r, bus.beat, bus.done); end
      tick();
      bus.g = 1'b0;
      #1;
      total++; if (bus.r !== 1'b0) begin bad++; $display("FAIL poke_not_taken r got=%0b exp=0", bus.r); end
      total++; if (bus.job_ready !== 1'b1) begin bad++; $display("FAIL poke_still_idle got=%0b exp=1", bus.job_ready); end
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.job_valid  = 1'b0;
    bus.job_len    = '0;
    bus.g          = 1'b0;
    bus.starve_clr = 1'b0;
    tick();
    tick();
    #1;
    total++; if (bus.r !== 1'b0) begin bad++; $display("FAIL rst_r got=%0b exp=0", bus.r); end
    total++; if (bus.job_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", bus.job_ready); end
    total++; if (bus.beat !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL rst_beat got=%0b%0b exp=00", bus.beat, bus.done); end
    total++; if (bus.beat_idx !== '0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", bus.beat_idx); end
    total++; if (bus.starve !== 1'b0) begin bad++; $display("FAIL rst_starve got=%0b exp=0", bus.starve); end
    total++; if (bus.jobs_done !== '0) begin bad++; $display("FAIL rst_jobs got=%0d exp=0", bus.jobs_done); end
    rst_n      = 1'b1;
    exp_jobs   = '0;
    exp_starve = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    run_job(2, 0, 1'b0);
    bus.g = 1'b0;
    #1;
    total++; if (bus.job_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%0b exp=1", bus.job_ready); end
    total++; if (bus.jobs_done !== CNT_W'(1)) begin bad++; $display("FAIL basic_jobs got=%0d exp=1", bus.jobs_done); end
  endtask

  task automatic test_preempt();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_job(3, 2, 1'b0);
  endtask

  task automatic test_starve();
    run_job(0, 3, 1'b0);
    total++; if (exp_starve !== 1'b1 || bus.starve !== 1'b1) begin bad++; $display("FAIL starve_sticky got=%0b exp=1", bus.starve); end
    bus.starve_clr = 1'b1;
    #1;
    total++; if (bus.starve !== 1'b1) begin bad++; $display("FAIL starve_before_clr got=%0b exp=1", bus.starve); end
    tick();
    bus.starve_clr = 1'b0;
    exp_starve     = 1'b0;
    #1;
    total++; if (bus.starve !== 1'b0) begin bad++; $display("FAIL starve_cleared got=%0b exp=0", bus.starve); end
  endtask

  task automatic test_idle_rel();
    bus.g = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      total++; if (bus.beat !== 1'b0 || bus.done !== 1'b0 || bus.r !== 1'b0) begin bad++; $display("FAIL idle_grant beat/done/r got=%0b%0b%0b exp=000", bus.beat, bus.done, bus.r); end
    end
    tick();
    run_job(1, 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    tick();
    bus.job_valid = 1'b1;
    bus.job_len   = LEN_W'(5);
    bus.g         = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    tick();
    tick();
    #1;
    total++; if (bus.beat !== 1'b1 || bus.beat_idx !== LEN_W'(2)) begin bad++; $display("FAIL mid_pre beat=%0b idx=%0d exp 1/2", bus.beat, bus.beat_idx); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.r !== 1'b0 || bus.beat !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL mid_rst r/beat/done got=%0b%0b%0b exp=000", bus.r, bus.beat, bus.done); end
    total++; if (bus.beat_idx !== '0 || bus.jobs_done !== '0) begin bad++; $display("FAIL mid_rst_cnt idx=%0d jobs=%0d exp=0/0", bus.beat_idx, bus.jobs_done); end
    total++; if (bus.job_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%0b exp=0", bus.job_ready); end
    bus.g = 1'b0;
    tick();
    rst_n      = 1'b1;
    exp_jobs   = '0;
    exp_starve = 1'b0;
    #1;
    total++; if (bus.job_ready !== 1'b1 || bus.r !== 1'b0) begin bad++; $display("FAIL mid_release ready=%0b r=%0b exp 1/0", bus.job_ready, bus.r); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) begin
      run_job(0, 0, 1'b0);
    end
    total++; if (bus.jobs_done !== '0) begin bad++; $display("FAIL b2b_wrap got=%0d exp=0", bus.jobs_done); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_job(int'($urandom_range(0, 15)), 1, 1'($urandom % 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_preempt();
    test_starve();
    test_idle_rel();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
